// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared VRAM geometry and draw engine state encoding
// Purpose: constants for the 64x32 1bpp frame buffer and the draw FSM state type.
// Ports: none (package).
package chip8_pkg;

    localparam int VRAM_W     = 64;
    localparam int VRAM_H     = 32;
    localparam int VRAM_BYTES = VRAM_W * VRAM_H / 8;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        ROW_WAIT,
        RD_L,
        WAIT_L,
        WR_L,
        RD_R,
        WAIT_R,
        WR_R,
        DONE
    } draw_state_t;

endpackage

// File: rtl/chip8_sprite_align.sv
// rtl/chip8_sprite_align.sv - splits one sprite row across two VRAM bytes
// Purpose: combinational placement of an 8-pixel sprite row at a bit offset.
// Ports:
//   spr_data  in   8  sprite row, MSB = leftmost pixel
//   shift     in   3  pixel offset inside the first VRAM byte (x[2:0])
//   mask_l    out  8  XOR mask for the byte holding the sprite's left edge
//   mask_r    out  8  XOR mask for the following byte
//   r_en      out  1  the right byte carries pixels (shift != 0)
module chip8_sprite_align
    import chip8_pkg::*;
(
    input  logic [7:0] spr_data,
    input  logic [2:0] shift,
    output logic [7:0] mask_l,
    output logic [7:0] mask_r,
    output logic       r_en
);

    // Shifting the row through a 16-bit window yields both halves at once;
    // pixels pushed past bit 8 land in the right-hand byte.
    logic [15:0] spread;

    assign spread = {spr_data, 8'h00} >> shift;
    assign mask_l = spread[15:8];
    assign mask_r = spread[7:0];
    assign r_en   = (shift != 3'd0);

endmodule

// File: rtl/chip8_draw_engine.sv
// rtl/chip8_draw_engine.sv - CHIP-8 CLS/DRW engine doing read-modify-write on VRAM
// Purpose: executes clear-screen and sprite draw ops against the video port of
// chip8_memory, XOR-ing sprite rows into the 64x32 frame buffer and reporting VF.
// Ports:
//   clk_in, rst_in (async, active-low)
//   cls_in / draw_in      start pulses, cls wins, ignored while busy_out
//   x_in, y_in, n_in      draw origin (x mod 64, y mod 32) and row count
//   spr_valid_in/spr_data_in/spr_ready_out  sprite byte stream
//   video_addr_out/we_out/valid_out/data_out/type_out, video_ready_in  request side
//   video_rvalid_in/video_rdata_in          read return
//   busy_out, done_out (1-cycle), collision_out (VF)
module chip8_draw_engine
    import chip8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CLIP  = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cls_in,
    input  logic             draw_in,
    input  logic [7:0]       x_in,
    input  logic [7:0]       y_in,
    input  logic [3:0]       n_in,
    input  logic             spr_valid_in,
    input  logic [WIDTH-1:0] spr_data_in,
    output logic             spr_ready_out,
    output logic [15:0]      video_addr_out,
    output logic             video_we_out,
    output logic             video_valid_out,
    output logic [WIDTH-1:0] video_data_out,
    output logic             video_type_out,
    input  logic             video_ready_in,
    input  logic             video_rvalid_in,
    input  logic [WIDTH-1:0] video_rdata_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             collision_out
);

    localparam logic [7:0] LAST_BYTE = 8'(VRAM_BYTES - 1);

    draw_state_t state_q, state_d, after_row;

    logic [5:0] x_q;
    logic [4:0] y_q;
    logic [3:0] n_q;
    logic [3:0] row_q;
    logic [7:0] clr_q;
    logic [7:0] spr_q;
    logic [7:0] old_q;
    logic       coll_q;

    logic [7:0] mask_l, mask_r;
    logic       r_en, r_do;
    logic [5:0] row_sum;
    logic       row_off, row_last;
    logic [2:0] col_l, col_r;
    logic [15:0] addr_l, addr_r;
    logic       vid_hs;
    logic       unused_hi_bits;

    assign unused_hi_bits = ^{x_in[7:6], y_in[7:5]};

    chip8_sprite_align u_align (
        .spr_data (spr_q),
        .shift    (x_q[2:0]),
        .mask_l   (mask_l),
        .mask_r   (mask_r),
        .r_en     (r_en)
    );

    // Row sum kept one bit wider so rows below the screen are detectable
    // before wrapping; with CLIP=0 the low five bits give the wrapped row.
    assign row_sum  = {1'b0, y_q} + {2'b00, row_q};
    assign row_off  = (CLIP != 0) && (row_sum >= 6'(VRAM_H));
    assign row_last = (row_q == (n_q - 4'd1));
    assign col_l    = x_q[5:3];
    assign col_r    = col_l + 3'd1;
    // Right half is dropped at the right edge when clipping; otherwise col_r wraps to 0.
    assign r_do     = r_en && !((CLIP != 0) && (col_l == 3'd7));
    assign addr_l   = {8'h00, row_sum[4:0], col_l};
    assign addr_r   = {8'h00, row_sum[4:0], col_r};
    assign after_row = row_last ? DONE : ROW_WAIT;
    assign vid_hs   = video_valid_out && video_ready_in;

    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);
    assign collision_out  = coll_q;
    assign video_type_out = 1'b0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        spr_ready_out   = 1'b0;
        video_valid_out = 1'b0;
        video_we_out    = 1'b0;
        video_addr_out  = 16'h0000;
        video_data_out  = '0;
        case (state_q)
            IDLE: begin
                if (cls_in) begin
                    state_d = CLR;
                end else if (draw_in) begin
                    state_d = (n_in == 4'd0) ? DONE : ROW_WAIT;
                end
            end
            CLR: begin
                video_valid_out = 1'b1;
                video_we_out    = 1'b1;
                video_addr_out  = {8'h00, clr_q};
                if (video_ready_in && (clr_q == LAST_BYTE)) begin
                    state_d = DONE;
                end
            end
            ROW_WAIT: begin
                spr_ready_out = 1'b1;
                if (spr_valid_in) begin
                    state_d = row_off ? after_row : RD_L;
                end
            end
            RD_L: begin
                video_valid_out = 1'b1;
                video_addr_out  = addr_l;
                if (video_ready_in) state_d = WAIT_L;
            end
            WAIT_L: begin
                if (video_rvalid_in) state_d = WR_L;
            end
            WR_L: begin
                video_valid_out = 1'b1;
                video_we_out    = 1'b1;
                video_addr_out  = addr_l;
                video_data_out  = old_q ^ mask_l;
                if (video_ready_in) state_d = r_do ? RD_R : after_row;
            end
            RD_R: begin
                video_valid_out = 1'b1;
                video_addr_out  = addr_r;
                if (video_ready_in) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (video_rvalid_in) state_d = WR_R;
            end
            WR_R: begin
                video_valid_out = 1'b1;
                video_we_out    = 1'b1;
                video_addr_out  = addr_r;
                video_data_out  = old_q ^ mask_r;
                if (video_ready_in) state_d = after_row;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q    <= '0;
            y_q    <= '0;
            n_q    <= '0;
            row_q  <= '0;
            clr_q  <= '0;
            spr_q  <= '0;
            old_q  <= '0;
            coll_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cls_in) begin
                        clr_q  <= '0;
                        coll_q <= 1'b0;
                    end else if (draw_in) begin
                        x_q    <= x_in[5:0];
                        y_q    <= y_in[4:0];
                        n_q    <= n_in;
                        row_q  <= '0;
                        coll_q <= 1'b0;
                    end
                end
                CLR: begin
                    if (vid_hs) clr_q <= clr_q + 8'd1;
                end
                ROW_WAIT: begin
                    if (spr_valid_in) begin
                        spr_q <= spr_data_in;
                        // A clipped row still consumes its byte but skips all traffic.
                        if (row_off) row_q <= row_q + 4'd1;
                    end
                end
                WAIT_L: begin
                    if (video_rvalid_in) begin
                        old_q  <= video_rdata_in;
                        coll_q <= coll_q | (|(video_rdata_in & mask_l));
                    end
                end
                WR_L: begin
                    if (vid_hs && !r_do) row_q <= row_q + 4'd1;
                end
                WAIT_R: begin
                    if (video_rvalid_in) begin
                        old_q  <= video_rdata_in;
                        coll_q <= coll_q | (|(video_rdata_in & mask_r));
                    end
                end
                WR_R: begin
                    if (vid_hs) row_q <= row_q + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
